// File: rtl/gtf_ch_rxsync_lock_ctrl.sv
// RX raw-data sync lock controller: qualifies a bitslip offset over periodic one-hot sync hits,
// holds it while locked, and drops lock after consecutive missed windows.
module gtf_ch_rxsync_lock_ctrl #(
  parameter int unsigned SYNC_PERIOD = 64,
  parameter int unsigned LOCK_CNT    = 4,
  parameter int unsigned MISS_CNT    = 3
) (
  input  logic        gtf_rxusrclk2_out,
  input  logic        gtwiz_reset_rx_sync,
  input  logic [15:0] det_vec,
  input  logic        ctrl_relock,
  output logic        locked,
  output logic [3:0]  slip_sel,
  output logic        sync_strobe,
  output logic        err_offset,
  output logic [1:0]  state_out,
  output logic [15:0] lock_loss_cnt
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [15:0] WIN_LAST = 16'(SYNC_PERIOD - 1);
  localparam logic [3:0]  LOCK_TGT = 4'(LOCK_CNT);
  localparam logic [3:0]  MISS_TGT = 4'(MISS_CNT);

  state_t      r_state;
  logic [15:0] r_per_cnt;
  logic [3:0]  r_good_cnt;
  logic [3:0]  r_miss_cnt;
  logic        r_locked;
  logic [3:0]  r_slip_sel;
  logic        r_sync_strobe;
  logic        r_err_offset;
  logic [15:0] r_lock_loss_cnt;

  logic        w_hit;
  logic [3:0]  w_hit_off;
  logic        w_win;
  logic        w_match;

  // Ambiguous multi-bit matches are rejected by requiring exactly one set bit.
  assign w_hit = (det_vec != 16'd0) && ((det_vec & (det_vec - 16'd1)) == 16'd0);

  always_comb begin
    w_hit_off = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (det_vec[i]) w_hit_off = 4'(i);
    end
  end

  assign w_win   = (r_per_cnt == WIN_LAST);
  assign w_match = w_hit && (w_hit_off == r_slip_sel);

  always_ff @(posedge gtf_rxusrclk2_out) begin
    if (gtwiz_reset_rx_sync) begin
      r_state         <= HUNT;
      r_per_cnt       <= 16'd0;
      r_good_cnt      <= 4'd0;
      r_miss_cnt      <= 4'd0;
      r_locked        <= 1'b0;
      r_slip_sel      <= 4'd0;
      r_sync_strobe   <= 1'b0;
      r_err_offset    <= 1'b0;
      r_lock_loss_cnt <= 16'd0;
    end else if (ctrl_relock) begin
      r_state       <= HUNT;
      r_per_cnt     <= 16'd0;
      r_good_cnt    <= 4'd0;
      r_miss_cnt    <= 4'd0;
      r_locked      <= 1'b0;
      r_sync_strobe <= 1'b0;
      r_err_offset  <= 1'b0;
    end else begin
      r_sync_strobe <= 1'b0;
      r_err_offset  <= 1'b0;
      r_per_cnt     <= r_per_cnt + 16'd1;
      case (r_state)
        HUNT: begin
          if (w_hit) begin
            r_slip_sel <= w_hit_off;
            r_good_cnt <= 4'd1;
            r_miss_cnt <= 4'd0;
            r_per_cnt  <= 16'd0;
            r_state    <= VERIFY;
          end
        end
        VERIFY: begin
          if (w_win) begin
            if (w_match) begin
              r_good_cnt <= r_good_cnt + 4'd1;
              r_per_cnt  <= 16'd0;
              if (r_good_cnt + 4'd1 == LOCK_TGT) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
              end
            end else begin
              r_state <= HUNT;
            end
          end else if (w_hit) begin
            r_state <= HUNT;
          end
        end
        LOCKED: begin
          // The window grid is anchored to the lock point, so it restarts on misses too.
          if (w_win) begin
            r_per_cnt <= 16'd0;
            if (w_match) begin
              r_sync_strobe <= 1'b1;
              r_miss_cnt    <= 4'd0;
            end else begin
              r_miss_cnt   <= r_miss_cnt + 4'd1;
              r_err_offset <= w_hit;
              if (r_miss_cnt + 4'd1 == MISS_TGT) begin
                r_state  <= HUNT;
                r_locked <= 1'b0;
                if (r_lock_loss_cnt != 16'hFFFF) r_lock_loss_cnt <= r_lock_loss_cnt + 16'd1;
              end
            end
          end else if (w_hit) begin
            r_err_offset <= 1'b1;
          end
        end
        default: begin
          r_state  <= HUNT;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign locked        = r_locked;
  assign slip_sel      = r_slip_sel;
  assign sync_strobe   = r_sync_strobe;
  assign err_offset    = r_err_offset;
  assign state_out     = r_state;
  assign lock_loss_cnt = r_lock_loss_cnt;

endmodule

// File: tb/tb_gtf_ch_rxsync_lock_ctrl.sv
// Bench for gtf_ch_rxsync_lock_ctrl: timestamp-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_gtf_ch_rxsync_lock_ctrl;

  localparam int P = 64;
  localparam int L = 4;
  localparam int M = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] detVec;
  logic        relock;
  logic        locked;
  logic [3:0]  slipSel;
  logic        syncStrobe;
  logic        errOffset;
  logic [1:0]  stateOut;
  logic [15:0] lockLossCnt;

  always #5 clock = ~clock;

  gtf_ch_rxsync_lock_ctrl #(
    .SYNC_PERIOD(P),
    .LOCK_CNT(L),
    .MISS_CNT(M)
  ) dut (
    .gtf_rxusrclk2_out  (clock),
    .gtwiz_reset_rx_sync(reset),
    .det_vec            (detVec),
    .ctrl_relock        (relock),
    .locked             (locked),
    .slip_sel           (slipSel),
    .sync_strobe        (syncStrobe),
    .err_offset         (errOffset),
    .state_out          (stateOut),
    .lock_loss_cnt      (lockLossCnt)
  );

  int checks = 0;
  int failures = 0;

  // Model state: mode 0/1/2 = hunting/verifying/locked, reference point kept as a cycle stamp.
  int          mState = 0;
  longint      cyc = 0;
  longint      refCyc = 0;
  int          mHits = 0;
  int          mMisses = 0;
  logic [3:0]  mSlip = 4'd0;
  logic        mStrobe = 1'b0;
  logic        mErr = 1'b0;
  int          mLossEvents = 0;
  bit          modelValid = 1'b0;
  int          lossBase = 0;
  int          lossBaseEvents = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int expectedLoss();
    int e;
    e = lossBase + mLossEvents - lossBaseEvents;
    if (e > 65535) e = 65535;
    return e;
  endfunction

  always @(posedge clock) begin : modelProc
    bit hit;
    bit good;
    bit onTime;
    int off;
    cyc = cyc + 1;
    mStrobe = 1'b0;
    mErr = 1'b0;
    if (reset) begin
      mState = 0; mSlip = 4'd0; mHits = 0; mMisses = 0; mLossEvents = 0;
      refCyc = cyc; modelValid = 1'b1;
    end else if (relock) begin
      mState = 0; mHits = 0; mMisses = 0;
    end else begin
      hit = ($countones(detVec) == 1);
      off = 0;
      for (int i = 0; i < 16; i++) if (detVec[i]) off = i;
      good = hit && (off == int'(mSlip));
      onTime = ((cyc - refCyc) == longint'(P));
      case (mState)
        0: if (hit) begin
          mSlip = 4'(off); mHits = 1; mMisses = 0; refCyc = cyc; mState = 1;
        end
        1: if (onTime) begin
          if (good) begin
            mHits = mHits + 1; refCyc = cyc;
            if (mHits == L) mState = 2;
          end else mState = 0;
        end else if (hit) mState = 0;
        2: if (onTime) begin
          refCyc = cyc;
          if (good) begin
            mStrobe = 1'b1; mMisses = 0;
          end else begin
            mMisses = mMisses + 1; mErr = hit;
            if (mMisses == M) begin
              mState = 0; mLossEvents = mLossEvents + 1;
            end
          end
        end else if (hit) mErr = 1'b1;
        default: ;
      endcase
    end
  end

  always @(negedge clock) begin
    if (modelValid) begin
      checkOutput("cyc_locked", locked, (mState == 2));
      checkOutput("cyc_state", stateOut, mState);
      checkOutput("cyc_slip", slipSel, mSlip);
      checkOutput("cyc_strobe", syncStrobe, mStrobe);
      checkOutput("cyc_err", errOffset, mErr);
      checkOutput("cyc_loss", lockLossCnt, expectedLoss());
    end
  end

  task automatic applyStimulus(input logic [15:0] v, input logic rl, input logic rst);
    @(negedge clock);
    detVec = v;
    relock = rl;
    reset = rst;
    @(posedge clock);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(16'h0000, 1'b0, 1'b0);
  endtask

  task automatic lockOn(input logic [15:0] v);
    applyStimulus(v, 1'b0, 1'b0);
    for (int k = 0; k < L - 1; k++) begin
      idle(P - 1);
      applyStimulus(v, 1'b0, 1'b0);
    end
  endtask

  initial begin
    detVec = 16'h0000;
    relock = 1'b0;
    reset = 1'b1;
    repeat (3) applyStimulus(16'h0000, 1'b0, 1'b1);
    #1;
    checkOutput("rst_state", stateOut, 0);
    checkOutput("rst_locked", locked, 0);
    checkOutput("rst_slip", slipSel, 0);
    checkOutput("rst_loss", lockLossCnt, 0);
    idle(5);

    // Scenario 1: periodic offset-5 syncs lock after the fourth hit.
    applyStimulus(16'h0020, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      idle(P - 1);
      applyStimulus(16'h0020, 1'b0, 1'b0);
    end
    #1;
    checkOutput("s1_verify_after3", stateOut, 1);
    checkOutput("s1_unlocked_after3", locked, 0);
    idle(P - 1);
    applyStimulus(16'h0020, 1'b0, 1'b0);
    #1;
    checkOutput("s1_locked", locked, 1);
    checkOutput("s1_slip", slipSel, 5);
    checkOutput("s1_state", stateOut, 2);
    for (int k = 0; k < 2; k++) begin
      idle(P - 1);
      applyStimulus(16'h0020, 1'b0, 1'b0);
      #1;
      checkOutput("s1_strobe", syncStrobe, 1);
    end

    // Scenario 2: two misses are tolerated, three drop lock.
    idle(2 * P);
    idle(P - 1);
    applyStimulus(16'h0020, 1'b0, 1'b0);
    #1;
    checkOutput("s2_strobe_after2miss", syncStrobe, 1);
    checkOutput("s2_still_locked", locked, 1);
    idle(3 * P - 1);
    #1;
    checkOutput("s2_locked_before3rd", locked, 1);
    idle(1);
    #1;
    checkOutput("s2_unlocked", locked, 0);
    checkOutput("s2_state", stateOut, 0);
    checkOutput("s2_loss", lockLossCnt, 1);

    // Scenario 3: wrong offset, early and late second hits all return to hunting.
    applyStimulus(16'h0020, 1'b0, 1'b0);
    #1;
    checkOutput("s3_verify", stateOut, 1);
    idle(P - 1);
    applyStimulus(16'h0200, 1'b0, 1'b0);
    #1;
    checkOutput("s3_wrong_off", stateOut, 0);
    applyStimulus(16'h0020, 1'b0, 1'b0);
    idle(P - 2);
    applyStimulus(16'h0020, 1'b0, 1'b0);
    #1;
    checkOutput("s3_early", stateOut, 0);
    applyStimulus(16'h0020, 1'b0, 1'b0);
    idle(P - 1);
    #1;
    checkOutput("s3_before_win", stateOut, 1);
    idle(1);
    #1;
    checkOutput("s3_late", stateOut, 0);
    idle(3);

    // Scenario 4: off-grid and wrong-offset hits while locked.
    lockOn(16'h0020);
    idle(29);
    applyStimulus(16'h0020, 1'b0, 1'b0);
    #1;
    checkOutput("s4_err_stray", errOffset, 1);
    checkOutput("s4_locked", locked, 1);
    idle(P - 31);
    applyStimulus(16'h0020, 1'b0, 1'b0);
    #1;
    checkOutput("s4_strobe_grid", syncStrobe, 1);
    idle(P - 1);
    applyStimulus(16'h0200, 1'b0, 1'b0);
    #1;
    checkOutput("s4_err_wrongoff", errOffset, 1);
    checkOutput("s4_nostrobe", syncStrobe, 0);
    idle(P - 1);
    applyStimulus(16'h0020, 1'b0, 1'b0);
    #1;
    checkOutput("s4_strobe_again", syncStrobe, 1);

    // Scenario 5: relock beats a simultaneous hit; two-bit matches are ignored.
    applyStimulus(16'h0020, 1'b1, 1'b0);
    #1;
    checkOutput("s5_relock_state", stateOut, 0);
    checkOutput("s5_relock_locked", locked, 0);
    checkOutput("s5_relock_loss", lockLossCnt, 1);
    applyStimulus(16'h0101, 1'b0, 1'b0);
    #1;
    checkOutput("s5_ambiguous", stateOut, 0);
    idle(10);

    // Scenario 6: loss counter saturation, then reset in the middle of verification.
    #1;
    force dut.r_lock_loss_cnt = 16'hFFFE;
    lossBase = 65534;
    lossBaseEvents = mLossEvents;
    #1;
    release dut.r_lock_loss_cnt;
    for (int k = 0; k < 2; k++) begin
      lockOn(16'h0008);
      idle(M * P);
      #1;
      checkOutput("s6_loss_sat", lockLossCnt, 16'hFFFF);
      checkOutput("s6_state", stateOut, 0);
    end
    applyStimulus(16'h0040, 1'b0, 1'b0);
    #1;
    checkOutput("s6_verify", stateOut, 1);
    checkOutput("s6_slip", slipSel, 6);
    idle(10);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    lossBase = 0;
    lossBaseEvents = 0;
    #1;
    checkOutput("s6_rst_state", stateOut, 0);
    checkOutput("s6_rst_slip", slipSel, 0);
    checkOutput("s6_rst_loss", lockLossCnt, 0);
    checkOutput("s6_rst_locked", locked, 0);
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
